decode_hazard_stage: RTL and testbench

Parametrised instruction-decode stage for the in-order RV32I pipeline, sitting between instruction memory and the execute stage. It holds the fetch PC and the decode→execute pipeline register. It computes per-source forwarding selects across a configurable number of downstream stages. It also handles load-use stalls with a configurable bubble count and accepts branch/jump redirects that flush the instruction in decode.

---
 rtl/decode_hazard_stage_if.sv | 40 ++++
 rtl/decode_hazard_stage.sv | 114 +++++++++++
 tb/tb_decode_hazard_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/decode_hazard_stage_if.sv
// decode_hazard_stage_if: bus between the decode stage and its fetch/execute neighbours.
// DECODE_HAZARD_PERF_EN adds the stall/flush performance counter outputs.
interface decode_hazard_stage_if #(
   parameter int XLEN      = 32,
   parameter int FWD_DEPTH = 3
);
   localparam int FW = $clog2(FWD_DEPTH + 1);
   logic [31:0]                 inst;
   logic                        freeze_cpu;
   logic                        redirect_valid;
   logic [XLEN-1:0]             redirect_pc;
   logic [(FWD_DEPTH-1)*32-1:0] down_inst;
   logic [XLEN-1:0]             pc;
   logic [4:0]                  addr1, addr2;
   logic                        rd1, rd2;
   logic [31:0]                 exe_inst;
   logic [XLEN-1:0]             exe_pc;
   logic                        exe_valid;
   logic [FW-1:0]               exe_rs1_forward, exe_rs2_forward;
   logic                        stall;
`ifdef DECODE_HAZARD_PERF_EN
   logic [31:0]                 perf_stall_cnt, perf_flush_cnt;
`endif
   modport slave (
      input  inst, freeze_cpu, redirect_valid, redirect_pc, down_inst,
`ifdef DECODE_HAZARD_PERF_EN
      output perf_stall_cnt, perf_flush_cnt,
`endif
      output pc, addr1, addr2, rd1, rd2, exe_inst, exe_pc, exe_valid,
             exe_rs1_forward, exe_rs2_forward, stall
   );
   modport master (
      output inst, freeze_cpu, redirect_valid, redirect_pc, down_inst,
`ifdef DECODE_HAZARD_PERF_EN
      input  perf_stall_cnt, perf_flush_cnt,
`endif
      input  pc, addr1, addr2, rd1, rd2, exe_inst, exe_pc, exe_valid,
             exe_rs1_forward, exe_rs2_forward, stall
   );
endinterface

// File: rtl/decode_hazard_stage.sv
// decode_hazard_stage: RV32I decode stage with forwarding selects, load-use stalls and redirect flush.
// DECODE_HAZARD_PERF_EN adds saturating stall/flush counters.
module decode_hazard_stage #(
   parameter int              XLEN         = 32,
   parameter int              FWD_DEPTH    = 3,
   parameter int              LOAD_BUBBLES = 1,
   parameter logic [XLEN-1:0] RESET_PC     = '0,
   parameter logic [31:0]     NOP          = 32'h00000013
) (
   input logic                  clk,
   input logic                  rst_n,
   decode_hazard_stage_if.slave bus
);
   localparam int FW = $clog2(FWD_DEPTH + 1);
   function automatic logic need_rd(input logic [6:0] op);
      return op inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h33};
   endfunction
   function automatic logic need_rs1(input logic [6:0] op);
      return op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
   endfunction
   function automatic logic need_rs2(input logic [6:0] op);
      return op inside {7'h63, 7'h23, 7'h33};
   endfunction
   function automatic logic hit(input logic [31:0] p, input logic v, input logic [4:0] a, input logic need);
      return v && need && a != 5'd0 && need_rd(p[6:0]) && p[11:7] == a;
   endfunction
   logic [XLEN-1:0] pc_q, pc_d, exe_pc_q, exe_pc_d;
   logic [31:0]     exe_inst_q, exe_inst_d;
   logic            exe_valid_q, exe_valid_d;
   logic [FW-1:0]   f1_q, f1_d, f2_q, f2_d, f1_c, f2_c;
   logic            stall_c, adv, redir, kill, take;
   logic [31:0]     prod [1:FWD_DEPTH];
   logic            pv [1:FWD_DEPTH];
   logic [4:0]      a1, a2;
   logic            n1, n2;
   assign a1 = bus.inst[19:15];
   assign a2 = bus.inst[24:20];
   assign n1 = need_rs1(bus.inst[6:0]);
   assign n2 = need_rs2(bus.inst[6:0]);
   always_comb begin
      prod[1] = exe_inst_q;
      pv[1]   = exe_valid_q;
      for (int k = 2; k <= FWD_DEPTH; k++) begin
         prod[k] = bus.down_inst[(k-2)*32 +: 32];
         pv[k]   = 1'b1;
      end
   end
   // Walk from the farthest stage inward so the nearest producer wins.
   always_comb begin
      f1_c    = '0;
      f2_c    = '0;
      stall_c = 1'b0;
      for (int k = FWD_DEPTH; k >= 1; k--) begin
         if (hit(prod[k], pv[k], a1, n1)) f1_c = FW'(k);
         if (hit(prod[k], pv[k], a2, n2)) f2_c = FW'(k);
         if (k <= LOAD_BUBBLES && prod[k][6:0] == 7'h03 &&
             (hit(prod[k], pv[k], a1, n1) || hit(prod[k], pv[k], a2, n2))) stall_c = 1'b1;
      end
   end
   assign adv   = !bus.freeze_cpu;
   assign redir = adv && bus.redirect_valid;
   assign kill  = adv && (bus.redirect_valid || stall_c);
   assign take  = adv && !bus.redirect_valid && !stall_c;
   always_comb begin
      pc_d        = redir ? bus.redirect_pc : take ? pc_q + XLEN'(4) : pc_q;
      exe_inst_d  = kill ? NOP : take ? bus.inst : exe_inst_q;
      exe_pc_d    = take ? pc_q : exe_pc_q;
      exe_valid_d = adv ? take : exe_valid_q;
      f1_d        = kill ? '0 : take ? f1_c : f1_q;
      f2_d        = kill ? '0 : take ? f2_c : f2_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         exe_inst_q  <= NOP;
         exe_pc_q    <= '0;
         exe_valid_q <= 1'b0;
         f1_q        <= '0;
         f2_q        <= '0;
      end else begin
         pc_q        <= pc_d;
         exe_inst_q  <= exe_inst_d;
         exe_pc_q    <= exe_pc_d;
         exe_valid_q <= exe_valid_d;
         f1_q        <= f1_d;
         f2_q        <= f2_d;
      end
   end
   assign bus.pc              = pc_q;
   assign bus.addr1           = a1;
   assign bus.addr2           = a2;
   assign bus.rd1             = adv && n1;
   assign bus.rd2             = adv && n2;
   assign bus.exe_inst        = exe_inst_q;
   assign bus.exe_pc          = exe_pc_q;
   assign bus.exe_valid       = exe_valid_q;
   assign bus.exe_rs1_forward = f1_q;
   assign bus.exe_rs2_forward = f2_q;
   assign bus.stall           = stall_c;
`ifdef DECODE_HAZARD_PERF_EN
   logic [31:0] perf_stall_q, perf_flush_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_q <= '0;
         perf_flush_q <= '0;
      end else begin
         if (adv && stall_c && perf_stall_q != '1) perf_stall_q <= perf_stall_q + 32'd1;
         if (redir && perf_flush_q != '1) perf_flush_q <= perf_flush_q + 32'd1;
      end
   end
   assign bus.perf_stall_cnt = perf_stall_q;
   assign bus.perf_flush_cnt = perf_flush_q;
`endif
endmodule

// File: tb/tb_decode_hazard_stage.sv
// tb_decode_hazard_stage: directed scoreboard bench for decode_hazard_stage (default parameters).
// Downstream stages 2..3 are modelled as a shift of exe_inst that holds while frozen.
module tb_decode_hazard_stage;
   localparam logic [31:0] NOP     = 32'h00000013;
   localparam logic [31:0] ADDI_X5 = 32'h00100293;
   localparam logic [31:0] ADD_655 = 32'h00528333;
   localparam logic [31:0] ADDI_X9 = 32'h00200493;
   localparam logic [31:0] ADDI_X0 = 32'h00500013;
   localparam logic [31:0] ADD_650 = 32'h00028333;
   localparam logic [31:0] LW_X7   = 32'h0000a383;
   localparam logic [31:0] ADD_870 = 32'h00038433;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [31:0] d2, d3;
   int total = 0;
   int bad = 0;
   typedef struct {
      string       tag;
      logic [31:0] pc, ei, ep, f1, f2;
      logic        v;
   } exp_t;
   exp_t sb [$];
   always #5 clk = ~clk;
   decode_hazard_stage_if #(.XLEN(32), .FWD_DEPTH(3)) bus ();
   decode_hazard_stage #(.XLEN(32), .FWD_DEPTH(3), .LOAD_BUBBLES(1), .RESET_PC(32'h0), .NOP(NOP))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d2 <= NOP;
         d3 <= NOP;
      end else if (!bus.freeze_cpu) begin
         d2 <= bus.exe_inst;
         d3 <= d2;
      end
   end
   assign bus.down_inst = {d3, d2};
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic drv(input logic [31:0] i, input logic fz, input logic rv, input logic [31:0] rpc);
      bus.inst           = i;
      bus.freeze_cpu     = fz;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      #1;
   endtask
   task automatic go(input string tag, input logic [31:0] pc, ei, ep, input logic v,
                     input logic [31:0] f1, f2);
      exp_t e;
      e.tag = tag; e.pc = pc; e.ei = ei; e.ep = ep; e.v = v; e.f1 = f1; e.f2 = f2;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({e.tag, ".pc"}, bus.pc, e.pc);
      chk({e.tag, ".exe_inst"}, bus.exe_inst, e.ei);
      chk({e.tag, ".exe_pc"}, bus.exe_pc, e.ep);
      chk({e.tag, ".exe_valid"}, 32'(bus.exe_valid), 32'(e.v));
      chk({e.tag, ".fwd1"}, 32'(bus.exe_rs1_forward), e.f1);
      chk({e.tag, ".fwd2"}, 32'(bus.exe_rs2_forward), e.f2);
   endtask
   initial begin
      drv(32'h0, 1'b0, 1'b0, 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      chk("rst.pc", bus.pc, 32'h0);
      chk("rst.exe_inst", bus.exe_inst, NOP);
      chk("rst.exe_pc", bus.exe_pc, 32'h0);
      chk("rst.exe_valid", 32'(bus.exe_valid), 32'h0);
      drv(ADDI_X5, 1'b0, 1'b0, 32'h0);
      go("addi_x5", 32'h4, ADDI_X5, 32'h0, 1'b1, 0, 0);
      drv(ADD_655, 1'b0, 1'b0, 32'h0);
      chk("dec.addr1", 32'(bus.addr1), 32'd5);
      chk("dec.addr2", 32'(bus.addr2), 32'd5);
      chk("dec.rd1", 32'(bus.rd1), 32'd1);
      chk("dec.rd2", 32'(bus.rd2), 32'd1);
      chk("dec.stall", 32'(bus.stall), 32'd0);
      go("fwd_exe", 32'h8, ADD_655, 32'h4, 1'b1, 1, 1);
      drv(ADDI_X5, 1'b0, 1'b0, 32'h0);
      go("addi_x5b", 32'hc, ADDI_X5, 32'h8, 1'b1, 0, 0);
      drv(ADDI_X9, 1'b0, 1'b0, 32'h0);
      go("unrelated", 32'h10, ADDI_X9, 32'hc, 1'b1, 0, 0);
      drv(ADD_655, 1'b0, 1'b0, 32'h0);
      go("fwd_mem", 32'h14, ADD_655, 32'h10, 1'b1, 2, 2);
      drv(ADDI_X0, 1'b0, 1'b0, 32'h0);
      go("addi_x0", 32'h18, ADDI_X0, 32'h14, 1'b1, 0, 0);
      drv(ADD_650, 1'b0, 1'b0, 32'h0);
      go("fwd_none", 32'h1c, ADD_650, 32'h18, 1'b1, 0, 0);
      drv(LW_X7, 1'b0, 1'b0, 32'h0);
      go("lw", 32'h20, LW_X7, 32'h1c, 1'b1, 0, 0);
      drv(ADD_870, 1'b0, 1'b0, 32'h0);
      chk("lu.stall_on", 32'(bus.stall), 32'd1);
      go("lu.bubble", 32'h20, NOP, 32'h1c, 1'b0, 0, 0);
      chk("lu.stall_off", 32'(bus.stall), 32'd0);
      go("lu.enter", 32'h24, ADD_870, 32'h20, 1'b1, 2, 0);
      drv(ADDI_X9, 1'b0, 1'b1, 32'h40);
      go("redir", 32'h40, NOP, 32'h20, 1'b0, 0, 0);
      drv(LW_X7, 1'b0, 1'b0, 32'h0);
      go("lw2", 32'h44, LW_X7, 32'h40, 1'b1, 0, 0);
      drv(ADD_870, 1'b0, 1'b1, 32'h80);
      chk("rs.stall", 32'(bus.stall), 32'd1);
      go("redir_wins", 32'h80, NOP, 32'h40, 1'b0, 0, 0);
      drv(ADDI_X9, 1'b0, 1'b0, 32'h0);
      go("after_redir", 32'h84, ADDI_X9, 32'h80, 1'b1, 0, 0);
      drv(ADDI_X5, 1'b0, 1'b0, 32'h0);
      go("addi_x5c", 32'h88, ADDI_X5, 32'h84, 1'b1, 0, 0);
      drv(ADD_655, 1'b0, 1'b0, 32'h0);
      go("fwd_exe2", 32'h8c, ADD_655, 32'h88, 1'b1, 1, 1);
      drv(ADD_655, 1'b1, 1'b0, 32'h0);
      chk("frz.rd1", 32'(bus.rd1), 32'd0);
      chk("frz.rd2", 32'(bus.rd2), 32'd0);
      for (int i = 0; i < 3; i++) go("freeze", 32'h8c, ADD_655, 32'h88, 1'b1, 1, 1);
      drv(LW_X7, 1'b0, 1'b0, 32'h0);
      go("lw3", 32'h90, LW_X7, 32'h8c, 1'b1, 0, 0);
      drv(ADD_870, 1'b1, 1'b0, 32'h0);
      go("frz_stall", 32'h90, LW_X7, 32'h8c, 1'b1, 0, 0);
      drv(ADD_870, 1'b0, 1'b0, 32'h0);
      chk("frz_stall.stall", 32'(bus.stall), 32'd1);
      go("frz_bubble", 32'h90, NOP, 32'h8c, 1'b0, 0, 0);
      go("frz_enter", 32'h94, ADD_870, 32'h90, 1'b1, 2, 0);
`ifdef DECODE_HAZARD_PERF_EN
      chk("perf.stall", bus.perf_stall_cnt, 32'd3);
      chk("perf.flush", bus.perf_flush_cnt, 32'd2);
`endif
      drv(ADDI_X9, 1'b0, 1'b0, 32'h0);
      rst_n = 1'b0;
      #1;
      chk("arst.pc", bus.pc, 32'h0);
      chk("arst.exe_inst", bus.exe_inst, NOP);
      chk("arst.exe_pc", bus.exe_pc, 32'h0);
      chk("arst.exe_valid", 32'(bus.exe_valid), 32'h0);
      chk("arst.fwd1", 32'(bus.exe_rs1_forward), 32'h0);
`ifdef DECODE_HAZARD_PERF_EN
      chk("arst.perf", bus.perf_stall_cnt, 32'd0);
`endif
      #2 rst_n = 1'b1;
      #1;
      chk("rel.pc0", bus.pc, 32'h0);
      go("rel.pc4", 32'h4, ADDI_X9, 32'h0, 1'b1, 0, 0);
      go("rel.pc8", 32'h8, ADDI_X9, 32'h4, 1'b1, 0, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
